// File: rtl/debug_unit_pkg.sv
// debug_unit_pkg: shared types and constants for the UART-style debug unit.
// Holds the FSM state enum, host command bytes, load ack byte and report packing helper.
package debug_unit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_LEN,
        LOAD_BYTE,
        LOAD_WRITE,
        RUN,
        STEP,
        REPORT
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h52;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] ACK_BYTE = 8'h06;

    // Report layout: PC in the low bytes, cycle count above it (sent LSB first).
    function automatic logic [63:0] pack_report(input logic [31:0] pc,
                                                input logic [31:0] cnt);
        return {cnt, pc};
    endfunction

endpackage

// File: rtl/debug_tx_serializer.sv
// debug_tx_serializer: shifts a loaded report (1..8 bytes) out through a valid/ready TX port.
// Ports: i_clk, i_reset (sync, active-low), i_load/i_len/i_data (report), i_tx_ready, o_tx_valid, o_tx_data, o_busy.
module debug_tx_serializer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [3:0]  i_len,
    input  logic [63:0] i_data,
    input  logic        i_tx_ready,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_busy
);

    logic [63:0] shreg;
    logic [3:0]  left;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            shreg <= 64'h0;
            left  <= 4'd0;
        end else if (i_load) begin
            shreg <= i_data;
            left  <= i_len;
        end else if (o_tx_valid && i_tx_ready) begin
            shreg <= {8'h00, shreg[63:8]};
            left  <= left - 4'd1;
        end
    end

    // Data only moves on an accepted byte, so it is held under backpressure.
    assign o_tx_valid = (left != 4'd0);
    assign o_tx_data  = shreg[7:0];
    assign o_busy     = o_tx_valid;

endmodule

// File: rtl/debug_unit.sv
// debug_unit: byte-command debug controller (load imem, run, single step, report PC/cycles).
// Ports: i_clk, i_reset (sync, active-low), i_rx_valid/i_rx_data, i_tx_ready/o_tx_valid/o_tx_data,
//        i_halt, i_pc, o_pipe_enable, o_imem_we/o_imem_addr/o_imem_data.
// Option: define DEBUG_UNIT_CYCLE_CNT_EN to add the cycle counter (8-byte run/step report).
import debug_unit_pkg::*;

module debug_unit #(
    parameter int IMEM_DEPTH_WORDS = 256,
    parameter int CLK_ENABLE_IDLE  = 0
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    input  logic        i_tx_ready,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_halt,
    input  logic [31:0] i_pc,
    output logic        o_pipe_enable,
    output logic        o_imem_we,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_imem_data
);

    localparam int IW = (IMEM_DEPTH_WORDS > 1) ? $clog2(IMEM_DEPTH_WORDS) : 1;
`ifdef DEBUG_UNIT_CYCLE_CNT_EN
    localparam logic [3:0] REPORT_LEN = 4'd8;
`else
    localparam logic [3:0] REPORT_LEN = 4'd4;
`endif

    state_t          state, state_n;
    logic [1:0]      byte_cnt;
    logic [31:0]     word;
    logic [IW-1:0]   idx;
    logic [7:0]      words_left;
    logic            ser_load;
    logic [3:0]      ser_len;
    logic [63:0]     ser_data;
    logic            ser_busy;
    logic            pipe_en;
    logic [63:0]     report_data;

    assign pipe_en = (state == RUN || state == STEP) ? !i_halt
                                                     : (CLK_ENABLE_IDLE != 0);
    // Reset forces the pipeline frozen regardless of the idle setting.
    assign o_pipe_enable = i_reset && pipe_en;

`ifdef DEBUG_UNIT_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] cnt_next;

    // Report uses the count including the enable of the cycle that enters REPORT.
    assign cnt_next = cycle_cnt + {31'b0, o_pipe_enable};

    always_ff @(posedge i_clk) begin
        if (!i_reset)
            cycle_cnt <= 32'h0;
        else if (state == LOAD_LEN && i_rx_valid && i_rx_data != 8'h00)
            cycle_cnt <= 32'h0;
        else
            cycle_cnt <= cnt_next;
    end

    assign report_data = pack_report(i_pc, cnt_next);
`else
    assign report_data = {32'h0, i_pc};
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state      <= IDLE;
            byte_cnt   <= 2'd0;
            word       <= 32'h0;
            idx        <= '0;
            words_left <= 8'd0;
        end else begin
            state <= state_n;
            if (state == LOAD_LEN && i_rx_valid) begin
                words_left <= i_rx_data;
                idx        <= '0;
                byte_cnt   <= 2'd0;
            end
            if (state == LOAD_BYTE && i_rx_valid) begin
                // Shift in from the top so the first byte ends at bits [7:0].
                word     <= {i_rx_data, word[31:8]};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == LOAD_WRITE) begin
                idx        <= idx + IW'(1);
                words_left <= words_left - 8'd1;
            end
        end
    end

    always_comb begin
        state_n  = state;
        ser_load = 1'b0;
        ser_len  = 4'd0;
        ser_data = 64'h0;
        unique case (state)
            IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: state_n = LOAD_LEN;
                        CMD_RUN:  state_n = RUN;
                        CMD_STEP: state_n = STEP;
                        default:  state_n = IDLE;
                    endcase
                end
            end
            LOAD_LEN: begin
                if (i_rx_valid)
                    state_n = (i_rx_data == 8'h00) ? IDLE : LOAD_BYTE;
            end
            LOAD_BYTE: begin
                if (i_rx_valid && byte_cnt == 2'd3)
                    state_n = LOAD_WRITE;
            end
            LOAD_WRITE: begin
                if (words_left == 8'd1) begin
                    state_n  = REPORT;
                    ser_load = 1'b1;
                    ser_len  = 4'd1;
                    ser_data = {56'h0, ACK_BYTE};
                end else begin
                    state_n = LOAD_BYTE;
                end
            end
            RUN: begin
                if (i_halt) begin
                    state_n  = REPORT;
                    ser_load = 1'b1;
                    ser_len  = REPORT_LEN;
                    ser_data = report_data;
                end
            end
            STEP: begin
                state_n  = REPORT;
                ser_load = 1'b1;
                ser_len  = REPORT_LEN;
                ser_data = report_data;
            end
            REPORT: begin
                if (!ser_busy)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign o_imem_we   = (state == LOAD_WRITE);
    assign o_imem_addr = {{(30 - IW){1'b0}}, idx, 2'b00};
    assign o_imem_data = word;

    debug_tx_serializer u_tx (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (ser_load),
        .i_len      (ser_len),
        .i_data     (ser_data),
        .i_tx_ready (i_tx_ready),
        .o_tx_valid (o_tx_valid),
        .o_tx_data  (o_tx_data),
        .o_busy     (ser_busy)
    );

endmodule

// File: tb/tb_debug_unit.sv
// tb_debug_unit: randomized self-checking bench for debug_unit.
// Monitors imem writes, TX bytes and enable cycles; compares against a host-side model.
module tb_debug_unit;

    localparam int DEPTH = 16;
`ifdef DEBUG_UNIT_CYCLE_CNT_EN
    localparam bit HAS_CNT = 1'b1;
`else
    localparam bit HAS_CNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_ready = 1'b1;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        halt = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        pipe_en;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;

    always #5 clk = ~clk;

    debug_unit #(
        .IMEM_DEPTH_WORDS (DEPTH),
        .CLK_ENABLE_IDLE  (0)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_rx_valid    (rx_valid),
        .i_rx_data     (rx_data),
        .i_tx_ready    (tx_ready),
        .o_tx_valid    (tx_valid),
        .o_tx_data     (tx_data),
        .i_halt        (halt),
        .i_pc          (pc),
        .o_pipe_enable (pipe_en),
        .o_imem_we     (imem_we),
        .o_imem_addr   (imem_addr),
        .o_imem_data   (imem_data)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int          errors = 0;
    int          checks = 0;
    wr_t         wr_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  exp_q[$];
    int          en_cnt = 0;
    logic [31:0] cnt_model = 32'h0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;

    // Monitor samples mid-cycle; inputs change only just after the rising edge.
    always @(negedge clk) begin
        if (imem_we) wr_q.push_back('{imem_addr, imem_data});
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (pipe_en) en_cnt++;
        if (prev_stall && tx_valid) begin
            checks++;
            if (tx_data !== prev_data) begin
                errors++;
                $display("FAIL tx_hold got=%h exp=%h", tx_data, prev_data);
            end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic clear_mon();
        wr_q.delete();
        tx_q.delete();
        en_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic wait_tx(input int n);
        int t = 0;
        while (tx_q.size() < n && t < 3000) begin
            @(posedge clk);
            t++;
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    function automatic void build_report(input logic [31:0] p);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'((p >> (8 * i)) & 32'hFF));
        if (HAS_CNT)
            for (int i = 0; i < 4; i++)
                exp_q.push_back(8'((cnt_model >> (8 * i)) & 32'hFF));
    endfunction

    task automatic do_load(input int n, input logic [31:0] w[$]);
        clear_mon();
        send_byte(8'h4C);
        send_byte(8'(n));
        for (int k = 0; k < n; k++)
            for (int b = 0; b < 4; b++)
                send_byte(8'((w[k] >> (8 * b)) & 32'hFF));
        if (n > 0) cnt_model = 32'h0;
        wait_tx(n > 0 ? 1 : 0);
    endtask

    task automatic do_run(input int k, input logic [31:0] p);
        clear_mon();
        pc = p;
        send_byte(8'h52);
        repeat (k) @(posedge clk);
        #1 halt = 1'b1;
        cnt_model += 32'(k);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 6;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got=%b exp=0", tx_valid); end
        if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
        if (imem_we !== 1'b0) begin errors++; $display("FAIL rst_we got=%b exp=0", imem_we); end
        if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
        if (imem_data !== 32'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", imem_data); end
        if (pipe_en !== 1'b0) begin errors++; $display("FAIL rst_pipe_en got=%b exp=0", pipe_en); end
        @(posedge clk); #1 rst_n = 1'b1;
        cnt_model = 32'h0;
    endtask

    task automatic test_load_basic();
        logic [31:0] w[$];
        w = '{32'h00000013, 32'hFFFFFFFF};
        do_load(2, w);
        checks++;
        if (wr_q.size() != 2) begin errors++; $display("FAIL load_count got=%0d exp=2", wr_q.size()); end
        for (int k = 0; k < 2 && k < wr_q.size(); k++) begin
            checks++;
            if (wr_q[k] !== {32'(4 * k), w[k]}) begin
                errors++;
                $display("FAIL load_wr%0d got=%h/%h exp=%h/%h", k, wr_q[k].a, wr_q[k].d, 4 * k, w[k]);
            end
        end
        checks++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin
            errors++;
            $display("FAIL load_ack got=%0d bytes exp=1 byte 06", tx_q.size());
        end
    endtask

    task automatic test_run();
        logic [31:0] w[$];
        w = '{32'($urandom)};
        do_load(1, w);
        clear_mon();
        pc = 32'h14;
        send_byte(8'h52);
        send_byte(8'h4C);
        repeat (3) @(posedge clk);
        #1 halt = 1'b1;
        cnt_model += 32'd5;
        build_report(32'h14);
        wait_tx(exp_q.size());
        checks++;
        if (en_cnt != 5) begin errors++; $display("FAIL run_enable got=%0d exp=5", en_cnt); end
        checks++;
        if (tx_q.size() != exp_q.size()) begin errors++; $display("FAIL run_len got=%0d exp=%0d", tx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== exp_q[i]) begin errors++; $display("FAIL run_byte%0d got=%h exp=%h", i, tx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_step_halted();
        logic [31:0] p;
        p = $urandom;
        clear_mon();
        halt = 1'b1;
        pc = p;
        send_byte(8'h53);
        build_report(p);
        wait_tx(exp_q.size());
        checks++;
        if (en_cnt != 0) begin errors++; $display("FAIL step_halt_enable got=%0d exp=0", en_cnt); end
        checks++;
        if (tx_q.size() != exp_q.size()) begin errors++; $display("FAIL step_halt_len got=%0d exp=%0d", tx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== exp_q[i]) begin errors++; $display("FAIL step_halt_byte%0d got=%h exp=%h", i, tx_q[i], exp_q[i]); end
        end
        clear_mon();
        send_byte(8'h52);
        wait_tx(exp_q.size());
        checks++;
        if (en_cnt != 0 || tx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL run_halt got=%0d en %0d bytes exp=0 en %0d bytes", en_cnt, tx_q.size(), exp_q.size());
        end
        halt = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [31:0] p;
        int t;
        p = $urandom;
        tx_ready = 1'b0;
        do_run(3, p);
        build_report(p);
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (tx_q.size() != 0 || tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall got=%0d bytes valid=%b exp=0 bytes valid=1", tx_q.size(), tx_valid);
        end
        tx_ready = 1'b1;
        wait_tx(exp_q.size());
        halt = 1'b0;
        checks++;
        if (en_cnt != 3 || tx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_len got=%0d en %0d bytes exp=3 en %0d bytes", en_cnt, tx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte%0d got=%h exp=%h", i, tx_q[i], exp_q[i]); end
        end
        p = $urandom;
        clear_mon();
        pc = p;
        send_byte(8'h53);
        cnt_model += 32'd1;
        build_report(p);
        t = 0;
        while (tx_q.size() < exp_q.size() && t < 3000) begin
            @(posedge clk); #1;
            tx_ready = 1'($urandom_range(0, 1));
            t++;
        end
        tx_ready = 1'b1;
        wait_tx(exp_q.size());
        checks++;
        if (tx_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_rand_len got=%0d exp=%0d", tx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_rand_byte%0d got=%h exp=%h", i, tx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_load_boundary();
        logic [31:0] w[$];
        int n;
        w.delete();
        do_load(0, w);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (wr_q.size() != 0 || tx_q.size() != 0) begin
            errors++;
            $display("FAIL load_zero got=%0d writes %0d bytes exp=0 0", wr_q.size(), tx_q.size());
        end
        n = DEPTH + 1;
        for (int k = 0; k < n; k++) w.push_back($urandom);
        do_load(n, w);
        checks++;
        if (wr_q.size() != n) begin errors++; $display("FAIL load_wrap_count got=%0d exp=%0d", wr_q.size(), n); end
        for (int k = 0; k < n && k < wr_q.size(); k++) begin
            checks++;
            if (wr_q[k] !== {32'(4 * (k % DEPTH)), w[k]}) begin
                errors++;
                $display("FAIL load_wrap_wr%0d got=%h/%h exp=%h/%h", k, wr_q[k].a, wr_q[k].d, 4 * (k % DEPTH), w[k]);
            end
        end
        checks++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'h06) begin errors++; $display("FAIL load_wrap_ack got=%0d bytes exp=1", tx_q.size()); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] p;
        clear_mon();
        send_byte(8'h4C);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cnt_model = 32'h0;
        send_byte(8'hCC);
        send_byte(8'hDD);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (wr_q.size() != 0 || tx_q.size() != 0) begin
            errors++;
            $display("FAIL abort_load got=%0d writes %0d bytes exp=0 0", wr_q.size(), tx_q.size());
        end
        clear_mon();
        tx_ready = 1'b0;
        send_byte(8'h53);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tx_ready = 1'b1;
        cnt_model = 32'h0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (tx_q.size() != 0) begin errors++; $display("FAIL abort_report got=%0d bytes exp=0", tx_q.size()); end
        p = $urandom;
        clear_mon();
        pc = p;
        send_byte(8'h53);
        cnt_model += 32'd1;
        build_report(p);
        wait_tx(exp_q.size());
        checks++;
        if (en_cnt != 1 || tx_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL abort_step got=%0d en %0d bytes exp=1 en %0d bytes", en_cnt, tx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_step_byte%0d got=%h exp=%h", i, tx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] w[$];
        logic [31:0] p;
        int n, k;
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 20);
            w.delete();
            for (int j = 0; j < n; j++) w.push_back($urandom);
            do_load(n, w);
            checks++;
            if (wr_q.size() != n || tx_q.size() != 1) begin
                errors++;
                $display("FAIL rnd%0d_load got=%0d writes %0d bytes exp=%0d 1", it, wr_q.size(), tx_q.size(), n);
            end
            for (int j = 0; j < n && j < wr_q.size(); j++) begin
                checks++;
                if (wr_q[j] !== {32'(4 * (j % DEPTH)), w[j]}) begin
                    errors++;
                    $display("FAIL rnd%0d_wr%0d got=%h/%h exp=%h/%h", it, j, wr_q[j].a, wr_q[j].d, 4 * (j % DEPTH), w[j]);
                end
            end
            k = $urandom_range(1, 8);
            p = $urandom;
            do_run(k, p);
            build_report(p);
            wait_tx(exp_q.size());
            halt = 1'b0;
            checks++;
            if (en_cnt != k || tx_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rnd%0d_run got=%0d en %0d bytes exp=%0d en %0d bytes", it, en_cnt, tx_q.size(), k, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
                checks++;
                if (tx_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_byte%0d got=%h exp=%h", it, i, tx_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_run();
        test_step_halted();
        test_backpressure();
        test_load_boundary();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_unit.md
DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 Parameter IMEM_DEPTH_WORDS, default 256, instruction-memory depth in 32-bit words (power of two).
REQ-002 Parameter CLK_ENABLE_IDLE, default 0, value of o_pipe_enable outside RUN/STEP (0 = pipeline frozen).
REQ-003 i_clk  input  1  single clock, all logic on rising edge.
REQ-004 i_reset  input  1  synchronous, active-low reset.
REQ-005 i_rx_valid  input  1  received byte strobe (one cycle per byte).
REQ-006 i_rx_data  input  8  received byte.
REQ-007 i_tx_ready  input  1  transmitter can accept a byte.
REQ-008 o_tx_valid  output  1  byte to transmit is valid.
REQ-009 o_tx_data  output  8  byte to transmit.
REQ-010 i_halt  input  1  pipeline has retired a HALT.
REQ-011 i_pc  input  32  current pipeline PC.
REQ-012 o_pipe_enable  output  1  pipeline advances one cycle when high.
REQ-013 o_imem_we  output  1  instruction-memory write strobe.
REQ-014 o_imem_addr  output  32  instruction-memory byte address.
REQ-015 o_imem_data  output  32  instruction word to write.

Function
REQ-016 FSM states SHALL be IDLE, LOAD_LEN, LOAD_BYTE, LOAD_WRITE, RUN, STEP, REPORT.
REQ-017 IDLE: byte 0x4C ('L') -> LOAD_LEN; 0x52 ('R') -> RUN; 0x53 ('S') -> STEP; any other byte discarded, stay IDLE.
REQ-018 LOAD_LEN: next byte N = word count; N=0 -> IDLE with no writes; else clear word index, clear cycle counter, -> LOAD_BYTE.
REQ-019 LOAD_BYTE: assemble 4 bytes little-endian; after 4th byte -> LOAD_WRITE.
REQ-020 LOAD_WRITE: o_imem_we high exactly one cycle, o_imem_addr = 4*(index mod IMEM_DEPTH_WORDS), o_imem_data = assembled word; index increments; -> LOAD_BYTE if words remain, else -> REPORT with single byte 0x06.
REQ-021 Word index SHALL wrap modulo IMEM_DEPTH_WORDS; N > depth overwrites from address 0.
REQ-022 RUN: o_pipe_enable = !i_halt (combinational from state and i_halt); first cycle with i_halt high -> REPORT; R with i_halt already high yields zero enable cycles.
REQ-023 STEP: o_pipe_enable high exactly one cycle unless i_halt high (then zero); -> REPORT next cycle.
REQ-024 Cycle counter (32-bit, wraps) increments on every cycle with o_pipe_enable high.
REQ-025 REPORT after RUN/STEP: send i_pc sampled on REPORT entry, 4 bytes LSB first, then cycle counter 4 bytes LSB first (8 bytes total).
REQ-026 TX handshake: byte transfers on an edge where o_tx_valid and i_tx_ready both high; o_tx_data stable while o_tx_valid high and not accepted; after last byte -> IDLE.
REQ-027 i_rx_valid bytes arriving in RUN, STEP, LOAD_WRITE or REPORT SHALL be dropped.
REQ-028 o_imem_we SHALL never be high in any state other than LOAD_WRITE; o_pipe_enable = CLK_ENABLE_IDLE in IDLE/LOAD_*/REPORT.

Reset
REQ-029 While i_reset low at an edge: state IDLE, o_tx_valid=0, o_tx_data=0, o_imem_we=0, o_imem_addr=0, o_imem_data=0, index, byte count and cycle counter 0.
REQ-030 o_pipe_enable SHALL be 0 during reset regardless of CLK_ENABLE_IDLE.
REQ-031 Reset mid-load or mid-report SHALL abort; partial word never written; no further bytes sent.

Configuration
REQ-032 Macro DEBUG_UNIT_CYCLE_CNT_EN defined: cycle counter present, RUN/STEP report is 8 bytes per REQ-025.
REQ-033 Macro undefined: no counter logic, RUN/STEP report is 4 bytes (PC only); load ack unchanged.

Structure
REQ-034 Shared package debug_unit_pkg SHALL hold state enum, command bytes 0x4C/0x52/0x53, ack byte 0x06.
REQ-035 Sub-module debug_tx_serializer SHALL shift a loaded report (up to 8 bytes, length input) through the TX handshake.

Verification
REQ-036 Send 4C 02 13 00 00 00 FF FF FF FF -> writes (0x0,0x00000013),(0x4,0xFFFFFFFF), one cycle each, then TX 06.
REQ-037 Load 1 word, send 52, i_halt rises after 5 enabled cycles, i_pc=0x14 -> enable high 5 cycles, TX 14 00 00 00 05 00 00 00.
REQ-038 i_halt high, send 53 -> zero enable cycles, TX PC + unchanged counter.
REQ-039 i_tx_ready low 10 cycles during report -> o_tx_data held, no byte lost or duplicated.
REQ-040 Load N=0 and N=IMEM_DEPTH_WORDS+1 -> no write / last word written at address 0.
REQ-041 i_reset low after 2 of 4 bytes, then release -> no write, IDLE, next 0x53 processed normally.
